// File: rtl/burst_memory.sv
// Single-port word memory with valid/ready bursts, programmable wait states,
// byte-lane write strobes and an error response for out-of-range beats.
module burst_memory #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 12,
    parameter int ADDR_WIDTH  = 4,
    parameter int WAIT_STATES = 2,
    parameter int LEN_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    output logic                  ready,
    output logic [WIDTH-1:0]      rdata,
    output logic                  error
);

    localparam int BYTES = WIDTH / 8;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_BEAT = 2'd2;

    localparam logic [1:0]            ST_GAP   = (WAIT_STATES == 0) ? ST_BEAT : ST_WAIT;
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(WAIT_STATES);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);

    logic [1:0]            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [ADDR_WIDTH:0]   beat_addr_reg, beat_addr_next;
    logic [LEN_WIDTH-1:0]  beats_left_reg, beats_left_next;
    logic                  wr_reg, wr_next;
    logic                  ready_reg;
    logic [WIDTH-1:0]      rdata_reg;
    logic                  error_reg;

    logic                  access;
    logic                  in_range;
    logic                  wr_en;
    logic [IDX_W-1:0]      mem_idx;
    logic [ADDR_WIDTH:0]   addr_sum;
    logic [ADDR_WIDTH:0]   addr_inc;
    logic [WIDTH-1:0]      rd_word;

    // A beat only happens while the requester still holds valid; a low valid aborts.
    assign access   = (state_reg == ST_BEAT) && valid;
    assign in_range = (beat_addr_reg < DEPTH_L);
    assign wr_en    = access && wr_reg && in_range;
    assign mem_idx  = beat_addr_reg[IDX_W-1:0];

    // The carry bit is sticky so a long burst can never wrap back into range.
    assign addr_sum = beat_addr_reg + 1'b1;
    assign addr_inc = {beat_addr_reg[ADDR_WIDTH] | addr_sum[ADDR_WIDTH],
                       addr_sum[ADDR_WIDTH-1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        lane_mem[IDX_W'(i)] <= '0;
                    end
                end else if (wr_en && wstrb[gi]) begin
                    lane_mem[mem_idx] <= wdata[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = lane_mem[mem_idx];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        beat_addr_next  = beat_addr_reg;
        beats_left_next = beats_left_reg;
        wr_next         = wr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (valid) begin
                    wr_next         = wr_rd;
                    beat_addr_next  = {1'b0, addr};
                    beats_left_next = len;
                    cnt_next        = CNT_LOAD;
                    state_next      = ST_GAP;
                end
            end
            ST_WAIT: begin
                if (!valid) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_next = ST_BEAT;
                    end
                end
            end
            ST_BEAT: begin
                if (!valid) begin
                    state_next = ST_IDLE;
                end else begin
                    beat_addr_next = addr_inc;
                    if (beats_left_reg == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        beats_left_next = beats_left_reg - 1'b1;
                        cnt_next        = CNT_LOAD;
                        state_next      = ST_GAP;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            beat_addr_reg  <= '0;
            beats_left_reg <= '0;
            wr_reg         <= 1'b0;
            ready_reg      <= 1'b0;
            rdata_reg      <= '0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            beat_addr_reg  <= beat_addr_next;
            beats_left_reg <= beats_left_next;
            wr_reg         <= wr_next;
            ready_reg      <= access;
            error_reg      <= access && !in_range;
            rdata_reg      <= (access && !wr_reg && in_range) ? rd_word : '0;
        end
    end

    assign ready = ready_reg;
    assign rdata = rdata_reg;
    assign error = error_reg;

endmodule

// File: tb/tb_burst_memory.sv
// Scoreboard bench for burst_memory: expected beats are queued when a burst is
// issued and compared by a monitor each time the memory returns ready.
module tb_burst_memory;

    localparam int WIDTH       = 32;
    localparam int DEPTH       = 12;
    localparam int ADDR_WIDTH  = 4;
    localparam int WAIT_STATES = 2;
    localparam int LEN_WIDTH   = 2;

    typedef struct {
        logic [WIDTH-1:0] rdata;
        logic             err;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  valid = 1'b0;
    logic                  wr_rd = 1'b0;
    logic [ADDR_WIDTH-1:0] addr = '0;
    logic [LEN_WIDTH-1:0]  len = '0;
    logic [WIDTH-1:0]      wdata = '0;
    logic [WIDTH/8-1:0]    wstrb = '0;
    logic                  ready;
    logic [WIDTH-1:0]      rdata;
    logic                  error;

    int               checks = 0;
    int               errors = 0;
    int               ready_cnt = 0;
    int               err_cnt = 0;
    logic [WIDTH-1:0] last_rdata = '0;
    logic             mon_en = 1'b0;
    exp_t             sb_q[$];
    exp_t             mon_e;
    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] burst_data [4];
    logic [3:0]       burst_strb [4];

    burst_memory #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH),
        .WAIT_STATES(WAIT_STATES), .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr),
        .len(len), .wdata(wdata), .wstrb(wstrb), .ready(ready),
        .rdata(rdata), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // Scoreboard monitor: every ready beat pops one expectation; idle cycles must be quiet.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (ready === 1'b1) begin
                ready_cnt++;
                last_rdata = rdata;
                if (error === 1'b1) err_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready rdata=%h error=%b at %0t", rdata, error, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (rdata !== mon_e.rdata || error !== mon_e.err) begin
                        errors++;
                        $display("FAIL beat_data got rdata=%h error=%b expected rdata=%h error=%b at %0t",
                                 rdata, error, mon_e.rdata, mon_e.err, $time);
                    end else begin
                        $display("beat rdata=%h error=%b at %0t", rdata, error, $time);
                    end
                end
            end else begin
                checks++;
                if (rdata !== '0 || error !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs got rdata=%h error=%b expected 0/0 at %0t", rdata, error, $time);
                end
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic run_burst(input logic wr, input int a, input int l, input int abort_after,
                             output int seen, output int bad);
        int   nb;
        int   ncomp;
        int   n;
        int   ba;
        logic got;
        exp_t e;
        nb    = l + 1;
        ncomp = (abort_after < nb) ? abort_after : nb;
        for (int k = 0; k < ncomp; k++) begin
            ba      = a + k;
            e.err   = (ba >= DEPTH);
            e.rdata = '0;
            if (wr) begin
                if (!e.err)
                    for (int b = 0; b < 4; b++)
                        if (burst_strb[k][b]) model[ba][8*b +: 8] = burst_data[k][8*b +: 8];
            end else if (!e.err) begin
                e.rdata = model[ba];
            end
            sb_q.push_back(e);
        end
        seen = 0;
        bad  = 0;
        @(negedge clk);
        valid = 1'b1;
        wr_rd = wr;
        addr  = ADDR_WIDTH'(a);
        len   = LEN_WIDTH'(l);
        wdata = burst_data[0];
        wstrb = burst_strb[0];
        @(posedge clk);
        for (int k = 0; k < ncomp; k++) begin
            n   = 0;
            got = 1'b0;
            while (!got && n < 20) begin
                @(posedge clk);
                #1;
                n++;
                if (ready === 1'b1) got = 1'b1;
            end
            if (!got) begin
                bad++;
                break;
            end
            if (n != WAIT_STATES + 1) bad++;
            seen++;
            if (k + 1 < nb) begin
                wdata = burst_data[k+1];
                wstrb = burst_strb[k+1];
            end
        end
        if (ncomp < nb) begin
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
    endtask

    task automatic test_reset();
        int seen, bad, e0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
        checks++;
        if (ready !== 1'b0 || rdata !== '0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b rdata=%h error=%b expected 0/0/0", ready, rdata, error);
        end
        mon_en = 1'b1;
        e0 = err_cnt;
        burst_data[0] = '0; burst_strb[0] = 4'h0;
        run_burst(1'b0, 5, 0, 99, seen, bad);
        @(negedge clk);
        checks++;
        if (seen !== 1 || bad !== 0) begin
            errors++;
            $display("FAIL reset_read_latency got beats=%0d bad=%0d expected 1/0", seen, bad);
        end
        checks++;
        if (last_rdata !== 32'h0 || err_cnt != e0) begin
            errors++;
            $display("FAIL reset_read_data got rdata=%h errs=%0d expected 0/0", last_rdata, err_cnt - e0);
        end
        $display("test_reset done");
    endtask

    task automatic test_strobes();
        int seen, bad;
        burst_data[0] = 32'hAABBCCDD; burst_strb[0] = 4'b1111;
        run_burst(1'b1, 3, 0, 99, seen, bad);
        burst_data[0] = 32'h11223344; burst_strb[0] = 4'b0101;
        run_burst(1'b1, 3, 0, 99, seen, bad);
        run_burst(1'b0, 3, 0, 99, seen, bad);
        @(negedge clk);
        checks++;
        if (seen !== 1 || bad !== 0 || last_rdata !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL strobe_merge got rdata=%h beats=%0d bad=%0d expected aa22cc44/1/0", last_rdata, seen, bad);
        end
        $display("test_strobes done");
    endtask

    task automatic test_burst();
        int seen, bad;
        for (int k = 0; k < 4; k++) begin
            burst_data[k] = WIDTH'(k + 1);
            burst_strb[k] = 4'hF;
        end
        run_burst(1'b1, 8, 3, 99, seen, bad);
        checks++;
        if (seen !== 4 || bad !== 0) begin
            errors++;
            $display("FAIL burst_write got beats=%0d bad=%0d expected 4/0", seen, bad);
        end
        run_burst(1'b0, 8, 3, 99, seen, bad);
        @(negedge clk);
        checks++;
        if (seen !== 4 || bad !== 0 || last_rdata !== 32'd4) begin
            errors++;
            $display("FAIL burst_read got beats=%0d bad=%0d last=%h expected 4/0/4", seen, bad, last_rdata);
        end
        $display("test_burst done");
    endtask

    task automatic test_range();
        int seen, bad, e0;
        e0 = err_cnt;
        run_burst(1'b0, 10, 3, 99, seen, bad);
        @(negedge clk);
        checks++;
        if (seen !== 4 || bad !== 0 || err_cnt - e0 != 2) begin
            errors++;
            $display("FAIL range_read got beats=%0d bad=%0d errs=%0d expected 4/0/2", seen, bad, err_cnt - e0);
        end
        for (int k = 0; k < 4; k++) begin
            burst_data[k] = 32'hDEAD0000 + WIDTH'(k);
            burst_strb[k] = 4'hF;
        end
        e0 = err_cnt;
        run_burst(1'b1, 14, 3, 99, seen, bad);
        @(negedge clk);
        checks++;
        if (seen !== 4 || bad !== 0 || err_cnt - e0 != 4) begin
            errors++;
            $display("FAIL range_write got beats=%0d bad=%0d errs=%0d expected 4/0/4", seen, bad, err_cnt - e0);
        end
        run_burst(1'b0, 0, 3, 99, seen, bad);
        @(negedge clk);
        checks++;
        if (last_rdata !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL range_no_wrap got rdata=%h expected aa22cc44", last_rdata);
        end
        $display("test_range done");
    endtask

    task automatic test_abort();
        int seen, bad, r0;
        run_burst(1'b0, 0, 3, 2, seen, bad);
        checks++;
        if (seen !== 2 || bad !== 0) begin
            errors++;
            $display("FAIL abort_beats got beats=%0d bad=%0d expected 2/0", seen, bad);
        end
        r0 = ready_cnt;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_cnt != r0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL abort_quiet got extra_ready=%0d pending=%0d expected 0/0", ready_cnt - r0, sb_q.size());
        end
        run_burst(1'b0, 8, 0, 99, seen, bad);
        @(negedge clk);
        checks++;
        if (seen !== 1 || bad !== 0 || last_rdata !== 32'd1) begin
            errors++;
            $display("FAIL abort_recover got beats=%0d bad=%0d rdata=%h expected 1/0/1", seen, bad, last_rdata);
        end
        $display("test_abort done");
    endtask

    task automatic test_back_to_back();
        int seen_w, bad_w, seen_r, bad_r;
        burst_data[0] = 32'h00000011; burst_strb[0] = 4'hF;
        burst_data[1] = 32'h00000022; burst_strb[1] = 4'hF;
        run_burst(1'b1, 6, 1, 99, seen_w, bad_w);
        run_burst(1'b0, 6, 1, 99, seen_r, bad_r);
        @(negedge clk);
        checks++;
        if (seen_w !== 2 || bad_w !== 0 || seen_r !== 2 || bad_r !== 0 || last_rdata !== 32'h22) begin
            errors++;
            $display("FAIL back_to_back got w=%0d/%0d r=%0d/%0d rdata=%h expected 2/0 2/0 22",
                     seen_w, bad_w, seen_r, bad_r, last_rdata);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        int   n, seen, bad, r0;
        logic got;
        exp_t e;
        e.rdata = '0;
        e.err   = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        valid = 1'b1; wr_rd = 1'b1; addr = 4'd4; len = 2'd3;
        wdata = 32'h5555AAAA; wstrb = 4'hF;
        @(posedge clk);
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (ready === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || n != WAIT_STATES + 1) begin
            errors++;
            $display("FAIL reset_mid_beat0 got ready=%b cycles=%0d expected 1/%0d", got, n, WAIT_STATES + 1);
        end
        wdata = 32'h6666BBBB;
        @(negedge clk);
        rst = 1'b0;
        r0 = ready_cnt;
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || rdata !== '0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got ready=%b rdata=%h error=%b expected 0/0/0", ready, rdata, error);
        end
        rst = 1'b1;
        valid = 1'b0;
        clear_model();
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready_cnt != r0) begin
            errors++;
            $display("FAIL reset_mid_quiet got extra_ready=%0d expected 0", ready_cnt - r0);
        end
        run_burst(1'b0, 4, 0, 99, seen, bad);
        @(negedge clk);
        checks++;
        if (seen !== 1 || bad !== 0 || last_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_word4 got beats=%0d bad=%0d rdata=%h expected 1/0/0", seen, bad, last_rdata);
        end
        run_burst(1'b0, 8, 0, 99, seen, bad);
        @(negedge clk);
        checks++;
        if (seen !== 1 || bad !== 0 || last_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_word8 got beats=%0d bad=%0d rdata=%h expected 1/0/0", seen, bad, last_rdata);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_strobes();
        test_burst();
        test_range();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got pending=%0d expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
